perceptron_feeder: RTL and testbench

PERCEPTRON_FEEDER -- requirements
Module: perceptron_feeder

---
 rtl/perceptron_pkg.sv | 27 ++
 rtl/perceptron_fifo.sv | 61 ++++++
 rtl/perceptron_feeder.sv | 162 ++++++++++++++++
 tb/tb_perceptron_feeder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types for the perceptron feeder: FSM state encoding and the
// weight-bank select codes driven on W1W0b_en_o.
package perceptron_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W0 = 3'd1,
    LOAD_W1 = 3'd2,
    SETTLE  = 3'd3,
    STREAM  = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    EN_RUN = 2'b00,
    EN_W0  = 2'b01,
    EN_W1  = 2'b10
  } wb_en_t;

  function automatic logic is_load(input state_t s);
    return (s == LOAD_W0) || (s == LOAD_W1);
  endfunction

endpackage

// File: rtl/perceptron_fifo.sv
// Registered stream FIFO; valid flag and head word are flops, so a word
// pushed in cycle N appears on the output no earlier than N+1.
module perceptron_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          val,
  output logic [DW-1:0] data,
  output logic          full_next_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
  logic [CW-1:0] count, count_d;
  logic [DW-1:0] head_d;

  // Next pointers/occupancy; head bypasses the array when the pushed word becomes the head.
  always_comb begin
    rd_ptr_d = rd_ptr + AW'(pop);
    wr_ptr_d = wr_ptr + AW'(push);
    count_d  = count + CW'(push) - CW'(pop);
    head_d   = (push && (wr_ptr == rd_ptr_d)) ? push_data : mem[rd_ptr_d];
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end
    full_next_c = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      val    <= 1'b0;
      data   <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      count  <= count_d;
      val    <= (count_d != '0);
      data   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/perceptron_feeder.sv
// Sequences a perceptron job: loads W0/bias and W1 words from the host stream,
// then forwards num_samples host words to the perceptron through a FIFO.
module perceptron_feeder
  import perceptron_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned NW0   = 4,
  parameter int unsigned NW1   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [7:0]        num_samples_i,
  input  logic              host_val_i,
  output logic              host_rdy_o,
  input  logic [DW-1:0]     host_data_i,
  output logic [1:0]        W1W0b_en_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DW-1:0]     wb_data_o,
  output logic              val_o,
  input  logic              rdy_i,
  output logic [DW-1:0]     data_o,
  output logic              busy_o,
  output logic              done_o
);

  state_t             state_q, state_d;
  wb_en_t             en_q, en_d;
  logic [CNT_W-1:0]   num_q, num_d, pushed_q, pushed_d, sent_q, sent_d;
  logic [ADDR_W-1:0]  idx_q, idx_d, wb_addr_d;
  logic [DW-1:0]      wb_data_d;
  logic               host_rdy_d, wb_we_d, busy_d, done_d;
  logic               host_xfer, push, pop, full_next_c;

  assign host_xfer  = host_val_i & host_rdy_o;
  assign push       = host_xfer & (state_q == STREAM) & ~abort_i;
  assign pop        = val_o & rdy_i;
  assign W1W0b_en_o = en_q;

  perceptron_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (abort_i),
    .push       (push),
    .push_data  (host_data_i),
    .pop        (pop),
    .val        (val_o),
    .data       (data_o),
    .full_next_c(full_next_c)
  );

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    idx_d     = idx_q;
    pushed_d  = pushed_q + CNT_W'(push);
    sent_d    = sent_q + CNT_W'(pop);
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_o;
    wb_data_d = wb_data_o;
    en_d      = en_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = LOAD_W0;
          num_d    = num_samples_i;
          idx_d    = '0;
          pushed_d = '0;
          sent_d   = '0;
          en_d     = EN_W0;
        end
      end
      LOAD_W0: begin
        en_d = EN_W0;
        if (host_xfer) begin
          wb_we_d   = 1'b1;
          wb_addr_d = idx_q;
          wb_data_d = host_data_i;
          if (idx_q == ADDR_W'(NW0 - 1)) begin
            idx_d   = '0;
            state_d = LOAD_W1;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      LOAD_W1: begin
        en_d = EN_W1;
        if (host_xfer) begin
          wb_we_d   = 1'b1;
          wb_addr_d = idx_q;
          wb_data_d = host_data_i;
          if (idx_q == ADDR_W'(NW1 - 1)) begin
            idx_d   = '0;
            state_d = SETTLE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      // The last W1 strobe lands in this cycle under EN_W1; run mode follows.
      SETTLE: begin
        en_d    = EN_RUN;
        state_d = (num_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (pop && (sent_d == num_q)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_i) begin
      state_d  = IDLE;
      en_d     = EN_RUN;
      wb_we_d  = 1'b0;
      idx_d    = '0;
      pushed_d = '0;
      sent_d   = '0;
    end

    // Registered handshake and status derived from the next state.
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    host_rdy_d = is_load(state_d) ||
                 ((state_d == STREAM) && !full_next_c && (pushed_d < num_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      en_q       <= EN_RUN;
      num_q      <= '0;
      pushed_q   <= '0;
      sent_q     <= '0;
      idx_q      <= '0;
      host_rdy_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      num_q      <= num_d;
      pushed_q   <= pushed_d;
      sent_q     <= sent_d;
      idx_q      <= idx_d;
      host_rdy_o <= host_rdy_d;
      wb_we_o    <= wb_we_d;
      wb_addr_o  <= wb_addr_d;
      wb_data_o  <= wb_data_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
    end
  end

endmodule

// File: tb/tb_perceptron_feeder.sv
// Directed scenarios for perceptron_feeder with hand-computed expectations.
module tb_perceptron_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [7:0] num_samples_i = 8'd0;
  logic       host_val_i = 1'b0;
  logic       host_rdy_o;
  logic [7:0] host_data_i = 8'd0;
  logic [1:0] W1W0b_en_o;
  logic       wb_we_o;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_data_o;
  logic       val_o;
  logic       rdy_i = 1'b0;
  logic [7:0] data_o;
  logic       busy_o;
  logic       done_o;

  perceptron_feeder #(.DW(8), .NW0(4), .NW1(2), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .num_samples_i(num_samples_i),
    .host_val_i   (host_val_i),
    .host_rdy_o   (host_rdy_o),
    .host_data_i  (host_data_i),
    .W1W0b_en_o   (W1W0b_en_o),
    .wb_we_o      (wb_we_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .val_o        (val_o),
    .rdy_i        (rdy_i),
    .data_o       (data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] words [16];
  int         hidx = 0;
  int         cyc = 0;
  int         hx_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         viol_en = 0;
  int         viol_hold = 0;
  logic [1:0] s_en [$];
  logic [2:0] s_addr [$];
  logic [7:0] s_data [$];
  int         s_cyc [$];
  logic [7:0] smp [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  // Mid-cycle observer: logs strobes, deliveries, done pulses and host transfers.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (wb_we_o) begin
        s_en.push_back(W1W0b_en_o);
        s_addr.push_back(wb_addr_o);
        s_data.push_back(wb_data_o);
        s_cyc.push_back(cyc);
        if (W1W0b_en_o == 2'b00) viol_en++;
      end
      if (val_o && rdy_i) smp.push_back(data_o);
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (val_o && (W1W0b_en_o != 2'b00)) viol_en++;
      if (prev_stall && (!val_o || (data_o !== prev_data))) viol_hold++;
      prev_stall = val_o && !rdy_i && !abort_i;
      prev_data  = data_o;
      if (host_val_i && host_rdy_o) begin
        hx_cnt++;
        hidx++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    host_data_i = (hidx < 16) ? words[hidx] : 8'h00;
  endtask

  task automatic new_job_data(input int base);
    for (int i = 0; i < 16; i++) words[i] = 8'(base + i);
    hidx = 0; hx_cnt = 0; done_cnt = 0; done_cyc = 0;
    viol_en = 0; viol_hold = 0;
    s_en.delete(); s_addr.delete(); s_data.delete(); s_cyc.delete(); smp.delete();
    host_data_i = words[0];
    host_val_i  = 1'b1;
  endtask

  task automatic start_job(input logic [7:0] num);
    num_samples_i = num;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      tick();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    tick();
  endtask

  task automatic wait_stream(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      tick();
      if (busy_o && (W1W0b_en_o == 2'b00)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({host_rdy_o, wb_we_o, wb_addr_o, wb_data_o, val_o, data_o, busy_o, done_o, W1W0b_en_o} !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs=%0h required 0",
               {host_rdy_o, wb_we_o, wb_addr_o, wb_data_o, val_o, data_o, busy_o, done_o, W1W0b_en_o});
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({host_rdy_o, wb_we_o, val_o, busy_o, done_o, W1W0b_en_o} !== '0) begin
      errors++;
      $display("FAIL reset_idle: outputs=%0h required 0",
               {host_rdy_o, wb_we_o, val_o, busy_o, done_o, W1W0b_en_o});
    end
  endtask

  task automatic test_basic_job();
    bit ok;
    new_job_data(8'h10);
    rdy_i = 1'b1;
    start_job(8'd3);
    checks++;
    if ({W1W0b_en_o, host_rdy_o, busy_o, wb_we_o} !== 5'b01_1_1_0) begin
      errors++;
      $display("FAIL first_load_cycle: en/rdy/busy/we=%b required 01110",
               {W1W0b_en_o, host_rdy_o, busy_o, wb_we_o});
    end
    run_until_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: done_o=0 required 1"); end
    checks++;
    if (s_en.size() != 6) begin
      errors++; $display("FAIL basic_strobe_count: got %0d required 6", s_en.size());
    end
    for (int i = 0; i < 6 && i < s_en.size(); i++) begin
      logic [1:0] ee; logic [2:0] ea; logic [7:0] ed;
      ee = (i < 4) ? 2'b01 : 2'b10;
      ea = 3'((i < 4) ? i : i - 4);
      ed = 8'(8'h10 + i);
      checks++;
      if ({s_en[i], s_addr[i], s_data[i]} !== {ee, ea, ed}) begin
        errors++;
        $display("FAIL basic_strobe%0d: en=%b addr=%0d data=%h required en=%b addr=%0d data=%h",
                 i, s_en[i], s_addr[i], s_data[i], ee, ea, ed);
      end
    end
    checks++;
    if (smp.size() != 3) begin
      errors++; $display("FAIL basic_sample_count: got %0d required 3", smp.size());
    end
    for (int i = 0; i < 3 && i < smp.size(); i++) begin
      checks++;
      if (smp[i] !== 8'(8'h16 + i)) begin
        errors++; $display("FAIL basic_sample%0d: got %h required %h", i, smp[i], 8'(8'h16 + i));
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt); end
    checks++;
    if (viol_en != 0) begin errors++; $display("FAIL basic_en_overlap: got %0d required 0", viol_en); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle_after: busy=%b required 0", busy_o); end
  endtask

  task automatic test_backpressure();
    bit ok;
    new_job_data(8'h20);
    rdy_i = 1'b0;
    start_job(8'd8);
    wait_stream(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_stream_timeout: STREAM not reached"); end
    for (int i = 0; i < 9; i++) begin
      start_i = (i == 2);
      num_samples_i = 8'd3;
      tick();
    end
    start_i = 1'b0;
    checks++;
    if (hx_cnt != 10) begin errors++; $display("FAIL bp_push_count: got %0d required 10", hx_cnt); end
    checks++;
    if (host_rdy_o !== 1'b0) begin errors++; $display("FAIL bp_host_rdy_full: got %b required 0", host_rdy_o); end
    checks++;
    if ({val_o, data_o} !== {1'b1, 8'h26}) begin
      errors++; $display("FAIL bp_head_hold: val=%b data=%h required val=1 data=26", val_o, data_o);
    end
    rdy_i = 1'b1;
    run_until_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: done_o=0 required 1"); end
    checks++;
    if (smp.size() != 8) begin errors++; $display("FAIL bp_sample_count: got %0d required 8", smp.size()); end
    for (int i = 0; i < 8 && i < smp.size(); i++) begin
      checks++;
      if (smp[i] !== 8'(8'h26 + i)) begin
        errors++; $display("FAIL bp_sample%0d: got %h required %h", i, smp[i], 8'(8'h26 + i));
      end
    end
    checks++;
    if (viol_hold != 0) begin errors++; $display("FAIL bp_stall_stability: got %0d required 0", viol_hold); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL bp_done_pulses: got %0d required 1", done_cnt); end
  endtask

  task automatic test_zero_samples();
    bit ok;
    new_job_data(8'h60);
    rdy_i = 1'b1;
    start_job(8'd0);
    run_until_done(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout: done_o=0 required 1"); end
    checks++;
    if (s_en.size() != 6) begin errors++; $display("FAIL zero_strobe_count: got %0d required 6", s_en.size()); end
    checks++;
    if (smp.size() != 0 || viol_en != 0) begin
      errors++; $display("FAIL zero_no_val: samples=%0d en_viol=%0d required 0/0", smp.size(), viol_en);
    end
    if (s_cyc.size() == 6) begin
      checks++;
      if (done_cyc != s_cyc[5] + 1) begin
        errors++; $display("FAIL zero_done_timing: done at %0d required %0d", done_cyc, s_cyc[5] + 1);
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d required 1", done_cnt); end
  endtask

  task automatic test_abort();
    bit ok;
    new_job_data(8'h30);
    rdy_i = 1'b0;
    start_job(8'd5);
    wait_stream(40, ok);
    for (int k = 0; k < 20 && hx_cnt < 8; k++) tick();
    tick();
    checks++;
    if (!ok || val_o !== 1'b1) begin
      errors++; $display("FAIL abort_precond: val=%b stream=%0d required val=1", val_o, ok);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if ({val_o, W1W0b_en_o, busy_o, host_rdy_o, wb_we_o, done_o} !== 7'b0) begin
      errors++;
      $display("FAIL abort_outputs: val/en/busy/rdy/we/done=%b required 0",
               {val_o, W1W0b_en_o, busy_o, host_rdy_o, wb_we_o, done_o});
    end
    tick(); tick(); tick();
    checks++;
    if (done_cnt != 0 || val_o !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: done=%0d val=%b required 0/0", done_cnt, val_o);
    end
    new_job_data(8'h40);
    rdy_i = 1'b1;
    start_job(8'd2);
    run_until_done(60, ok);
    checks++;
    if (!ok || s_data.size() != 6) begin
      errors++; $display("FAIL abort_rerun_strobes: got %0d required 6", s_data.size());
    end
    for (int i = 0; i < 6 && i < s_data.size(); i++) begin
      checks++;
      if (s_data[i] !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL abort_rerun_strobe%0d: got %h required %h", i, s_data[i], 8'(8'h40 + i));
      end
    end
    checks++;
    if (smp.size() != 2 || (smp.size() == 2 && (smp[0] !== 8'h46 || smp[1] !== 8'h47))) begin
      errors++; $display("FAIL abort_rerun_samples: count=%0d required 2 words 46,47", smp.size());
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL abort_rerun_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    new_job_data(8'h50);
    rdy_i = 1'b1;
    start_job(8'd2);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (W1W0b_en_o == 2'b10) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_precond: en=%b required 10", W1W0b_en_o); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({host_rdy_o, wb_we_o, wb_addr_o, wb_data_o, val_o, data_o, busy_o, done_o, W1W0b_en_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: outputs=%0h required 0",
               {host_rdy_o, wb_we_o, wb_addr_o, wb_data_o, val_o, data_o, busy_o, done_o, W1W0b_en_o});
    end
    tick();
    reset = 1'b1;
    s_en.delete(); s_addr.delete(); s_data.delete(); s_cyc.delete();
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (s_en.size() != 0 || busy_o !== 1'b0 || host_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: strobes=%0d busy=%b rdy=%b required 0/0/0", s_en.size(), busy_o, host_rdy_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_backpressure();
    test_zero_samples();
    test_abort();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
